// File: rtl/serial_word_comparator.sv
// Bit-serial MSB-first magnitude/equality comparator with a start/busy/done handshake.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends RUN on the first differing bit.
module serial_word_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             match,
    output logic [1:0]       state_dbg
);

    localparam int IDX_W = $clog2(WIDTH);

    // Handshake: start is sampled only in IDLE and the operands are latched on
    // that edge; busy is high for every RUN cycle; done pulses for one cycle in
    // DONE, where eq/lt/gt/match are already valid and then held until the next
    // accept. A start seen while busy or done is high is dropped, not queued.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [1:0]       mode_q;
    logic [IDX_W-1:0] idx_q;
    logic             diff_q;
    logic             eq_q;
    logic             lt_q;
    logic             gt_q;
    logic             match_q;

    logic a_bit;
    logic b_bit;
    logic first_diff;
    logic at_sign;
    logic last_idx;
    logic run_last;
    logic eq_n;
    logic lt_n;
    logic gt_n;
    logic match_n;

    assign a_bit      = a_q[idx_q];
    assign b_bit      = b_q[idx_q];
    assign first_diff = !diff_q && (a_bit != b_bit);
    assign at_sign    = (idx_q == IDX_W'(WIDTH - 1));
    assign last_idx   = (idx_q == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign run_last = last_idx || first_diff;
`else
    assign run_last = last_idx;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (run_last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Result of examining the current bit; the sign bit flips the sense in signed mode.
    always_comb begin
        eq_n = eq_q;
        lt_n = lt_q;
        gt_n = gt_q;
        if (state_q == ST_RUN) begin
            if (first_diff) begin
                if (signed_q && at_sign) begin
                    lt_n = a_bit;
                    gt_n = !a_bit;
                end else begin
                    gt_n = a_bit;
                    lt_n = !a_bit;
                end
            end else if (last_idx && !diff_q) begin
                eq_n = 1'b1;
            end
        end
    end

    always_comb begin
        match_n = 1'b0;
        case (mode_q)
            2'b00: match_n = eq_n;
            2'b01: match_n = !eq_n;
            2'b10: match_n = lt_n;
            2'b11: match_n = gt_n;
            default: match_n = 1'b0;
        endcase
    end

    // Datapath: operand latch, bit index and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            mode_q   <= 2'b00;
            idx_q    <= '0;
            diff_q   <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= signed_mode;
                        mode_q   <= mode;
                        idx_q    <= IDX_W'(WIDTH - 1);
                        diff_q   <= 1'b0;
                        eq_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        gt_q     <= 1'b0;
                        match_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    eq_q <= eq_n;
                    lt_q <= lt_n;
                    gt_q <= gt_n;
                    if (first_diff) diff_q <= 1'b1;
                    if (!last_idx) idx_q <= idx_q - IDX_W'(1);
                    // match is registered on the way into DONE so it is valid with done.
                    if (run_last) match_q <= match_n;
                end
                default: ;
            endcase
        end
    end

    assign eq        = eq_q;
    assign lt        = lt_q;
    assign gt        = gt_q;
    assign match     = match_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Table-driven bench for serial_word_comparator (WIDTH=8) plus hand-written
// sequences for start-while-busy and reset-mid-RUN.
module tb_serial_word_comparator;

    localparam int WIDTH = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;
    logic             match;
    logic [1:0]       state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    serial_word_comparator #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .mode        (mode),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt),
        .match       (match),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       sm;
        logic [1:0] md;
        logic [3:0] res;        // {eq, lt, gt, match}
        int         done_full;
        int         done_early;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one start, scrambles the inputs after accept, and waits for done.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsm,
                          input logic [1:0] tmode, output int done_cyc,
                          output int busy_cnt, output logic [3:0] res);
        @(negedge clk);
        a = ta;
        b = tb_v;
        signed_mode = tsm;
        mode = tmode;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta;
        b = ~tb_v;
        signed_mode = ~tsm;
        mode = ~tmode;
        done_cyc = -1;
        busy_cnt = 0;
        res = '0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c;
                res = {eq, lt, gt, match};
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int         dc;
        int         bc;
        int         exp_dc;
        int         dones;
        logic [3:0] r;

        vecs[0]  = '{8'h5A, 8'h5A, 1'b0, 2'b00, 4'b1001, 9, 9};
        vecs[1]  = '{8'h80, 8'h7F, 1'b0, 2'b11, 4'b0011, 9, 2};
        vecs[2]  = '{8'h80, 8'h7F, 1'b1, 2'b11, 4'b0100, 9, 2};
        vecs[3]  = '{8'h03, 8'h02, 1'b1, 2'b01, 4'b0011, 9, 9};
        vecs[4]  = '{8'h7F, 8'h80, 1'b1, 2'b10, 4'b0010, 9, 2};
        vecs[5]  = '{8'hFF, 8'h01, 1'b1, 2'b10, 4'b0101, 9, 2};
        vecs[6]  = '{8'hFE, 8'hFF, 1'b1, 2'b00, 4'b0100, 9, 9};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 2'b01, 4'b1000, 9, 9};
        vecs[8]  = '{8'h0F, 8'h10, 1'b0, 2'b10, 4'b0101, 9, 5};
        vecs[9]  = '{8'hC3, 8'hC1, 1'b0, 2'b11, 4'b0011, 9, 8};
        vecs[10] = '{8'h40, 8'h80, 1'b1, 2'b11, 4'b0011, 9, 2};
        vecs[11] = '{8'h40, 8'h80, 1'b0, 2'b11, 4'b0100, 9, 2};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, eq, lt, gt, match, state_dbg}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            exp_dc = EARLY ? vecs[i].done_early : vecs[i].done_full;
            run_op(vecs[i].va, vecs[i].vb, vecs[i].sm, vecs[i].md, dc, bc, r);
            check($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(exp_dc));
            check($sformatf("v%0d_busy_len", i), 64'(bc), 64'(exp_dc - 1));
            check($sformatf("v%0d_result", i), 64'(r), 64'(vecs[i].res));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_after_done", i), {done, state_dbg, eq, lt, gt, match},
                  {3'b000, vecs[i].res});
        end

        // Second start during RUN must be ignored.
        exp_dc = EARLY ? 4 : 9;
        @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        signed_mode = 1'b0;
        mode = 2'b10;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'h00;
        mode = 2'b00;
        dones = 0;
        dc = -1;
        bc = 0;
        r = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                dones++;
                if (dc < 0) begin
                    dc = c;
                    r = {eq, lt, gt, match};
                end
            end
            @(posedge clk);
            #1;
        end
        check("busy_start_done_count", 64'(dones), 64'd1);
        check("busy_start_done_cycle", 64'(dc), 64'(exp_dc));
        check("busy_start_busy_len", 64'(bc), 64'(exp_dc - 1));
        check("busy_start_result", 64'(r), 64'b0101);

        // Reset asserted in cycle 3 of a full-length compare.
        @(negedge clk);
        a = 8'h33;
        b = 8'h33;
        signed_mode = 1'b0;
        mode = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("midrun_busy_c1", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midrun_busy_c3", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_reset_outputs", {busy, done, eq, lt, gt, match, state_dbg}, 8'h00);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("midrun_no_done", 64'(dones), 64'd0);
        check("midrun_idle", 64'(state_dbg), 64'd0);

        run_op(8'h01, 8'h01, 1'b0, 2'b00, dc, bc, r);
        check("post_reset_done_cycle", 64'(dc), 64'd9);
        check("post_reset_result", 64'(r), 64'b1001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
